// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 scan/refresh controller that shifts one scan line of pixels,
// latches it, and lights the row for ON_CYCLES clocks, pulsing shift once per frame.
module hub75_scan_driver #(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 16,
    parameter int COL_W     = 6,
    parameter int ROW_W     = 4,
    parameter int ON_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             shift,
    input  logic             R0,
    input  logic             G0,
    input  logic             B0,
    input  logic             R1,
    input  logic             G1,
    input  logic             B1,
    output logic             hub_clk,
    output logic             hub_lat,
    output logic             hub_oe_n,
    output logic [ROW_W-1:0] hub_addr,
    output logic             hub_r0,
    output logic             hub_g0,
    output logic             hub_b0,
    output logic             hub_r1,
    output logic             hub_g1,
    output logic             hub_b1
);
    localparam int CNT_W = ON_CYCLES > 1 ? $clog2(ON_CYCLES) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ON_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] addr_q, addr_d;
    logic [5:0]       rgb_q, rgb_d;
    logic             clk_q, clk_d;
    logic             lat_q, lat_d;
    logic             oe_n_q, oe_n_d;
    logic             shift_q, shift_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        rgb_d   = rgb_q;
        case (state_q)
            IDLE: if (en) begin
                state_d = SHIFT;
                col_d   = '0;
                phase_d = 1'b0;
            end
            SHIFT: begin
                phase_d = ~phase_q;
                // sample at the end of phase 0 so the generator gets a full clock per pixel
                if (!phase_q) rgb_d = {R0, G0, B0, R1, G1, B1};
                else if (col_q == COL_LAST) state_d = BLANK;
                else col_d = col_q + 1'b1;
            end
            BLANK: begin
                state_d = LATCH;
                addr_d  = row_q;
            end
            LATCH: begin
                state_d = DISPLAY;
                cnt_d   = '0;
            end
            DISPLAY: if (cnt_q == CNT_LAST) begin
                state_d = en ? SHIFT : IDLE;
                col_d   = '0;
                phase_d = 1'b0;
                row_d   = row_q == ROW_LAST ? '0 : row_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they line up with the state they describe
        clk_d   = state_q == SHIFT && phase_q;
        lat_d   = state_d == LATCH;
        oe_n_d  = state_d != DISPLAY;
        shift_d = state_d == DISPLAY && cnt_d == CNT_LAST && row_q == ROW_LAST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            rgb_q   <= '0;
            clk_q   <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            rgb_q   <= rgb_d;
            clk_q   <= clk_d;
            lat_q   <= lat_d;
            oe_n_q  <= oe_n_d;
            shift_q <= shift_d;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign shift    = shift_q;
    assign hub_clk  = clk_q;
    assign hub_lat  = lat_q;
    assign hub_oe_n = oe_n_q;
    assign hub_addr = addr_q;
    assign {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = rgb_q;
endmodule
